// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter slice.
// Holds the shifter mode encodings and the requester port IDs.
package shift_pkg;

  localparam logic [1:0] SHIFT_SLL  = 2'd0;
  localparam logic [1:0] SHIFT_SRA  = 2'd1;
  localparam logic [1:0] SHIFT_ROR  = 2'd2;
  localparam logic [1:0] SHIFT_NONE = 2'd3;

  localparam logic PORT_ALU = 1'b0;
  localparam logic PORT_BF  = 1'b1;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Combinational 16-bit shifter.
// Ports:
//   data_i   - operand (treated as signed for SRA)
//   amt_i    - shift amount 0..15
//   mode_i   - SLL / SRA / ROR / pass-through
//   result_o - shifted result
module shifter
  import shift_pkg::*;
(
  input  logic [15:0] data_i,
  input  logic [3:0]  amt_i,
  input  logic [1:0]  mode_i,
  output logic [15:0] result_o
);

  always_comb begin
    result_o = data_i;
    case (mode_i)
      SHIFT_SLL: result_o = data_i << amt_i;
      SHIFT_SRA: result_o = $unsigned($signed(data_i) >>> amt_i);
      // A left shift by 16 on a 16-bit value yields zero, so amt=0 returns data_i.
      SHIFT_ROR: result_o = (data_i >> amt_i) | (data_i << (5'd16 - {1'b0, amt_i}));
      default:   result_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port arbiter in front of one shared shifter, with a one-entry
// response register tagged by the winning port.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   reqN_valid/ready/data/amt/mode  - requester N handshake and operands
//   rsp_valid/ready/data/id         - registered response and its source port
//   gnt_cnt0, gnt_cnt1              - saturating per-port grant counters
module shift_arbiter
  import shift_pkg::*;
#(
  parameter bit          RR_EN = 1'b1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_data,
  input  logic [3:0]       req0_amt,
  input  logic [1:0]       req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_data,
  input  logic [3:0]       req1_amt,
  input  logic [1:0]       req1_mode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic             rsp_id,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [15:0]      rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic             last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic        can_accept;
  logic        gnt1;
  logic        hs;
  logic [15:0] sh_data;
  logic [3:0]  sh_amt;
  logic [1:0]  sh_mode;
  logic [15:0] sh_result;

  assign can_accept = !rsp_valid_q || rsp_ready;

  // Port 1 wins when alone, or under round-robin when port 0 was served last.
  assign gnt1 = req1_valid && (!req0_valid || (RR_EN && (last_gnt_q == PORT_ALU)));
  assign hs   = can_accept && (req0_valid || req1_valid);

  assign req0_ready = can_accept && req0_valid && !gnt1;
  assign req1_ready = can_accept && gnt1;

  assign sh_data = gnt1 ? req1_data : req0_data;
  assign sh_amt  = gnt1 ? req1_amt  : req0_amt;
  assign sh_mode = gnt1 ? req1_mode : req0_mode;

  shifter u_shifter (
    .data_i   (sh_data),
    .amt_i    (sh_amt),
    .mode_i   (sh_mode),
    .result_o (sh_result)
  );

  // rsp_valid doubles as the IDLE/FULL state; no separate state register.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    last_gnt_d  = last_gnt_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    if (hs) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = sh_result;
      rsp_id_d    = gnt1;
      last_gnt_d  = gnt1;
      if (gnt1) begin
        if (cnt1_q != '1) cnt1_d = cnt1_q + 1'b1;
      end else begin
        if (cnt0_q != '1) cnt0_d = cnt0_q + 1'b1;
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= PORT_ALU;
      last_gnt_q  <= PORT_BF;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      last_gnt_q  <= last_gnt_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign gnt_cnt0  = cnt0_q;
  assign gnt_cnt1  = cnt1_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: round-robin, fixed-priority and
// 2-bit-counter instances share one set of stimulus.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [15:0] req0_data, req1_data;
  logic [3:0]  req0_amt, req1_amt;
  logic [1:0]  req0_mode, req1_mode;

  logic        r0rdy_a, r1rdy_a, rv_a, rid_a;
  logic [15:0] rd_a;
  logic [7:0]  c0_a, c1_a;
  logic        r0rdy_f, r1rdy_f, rv_f, rid_f;
  logic [15:0] rd_f;
  logic [7:0]  c0_f, c1_f;
  logic        r0rdy_s, r1rdy_s, rv_s, rid_s;
  logic [15:0] rd_s;
  logic [1:0]  c0_s, c1_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_arbiter #(.RR_EN(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(r0rdy_a), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(r1rdy_a), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_mode(req1_mode),
    .rsp_valid(rv_a), .rsp_ready(rsp_ready), .rsp_data(rd_a), .rsp_id(rid_a),
    .gnt_cnt0(c0_a), .gnt_cnt1(c1_a)
  );

  shift_arbiter #(.RR_EN(1'b0), .CNT_W(8)) dut_f (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(r0rdy_f), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(r1rdy_f), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_mode(req1_mode),
    .rsp_valid(rv_f), .rsp_ready(rsp_ready), .rsp_data(rd_f), .rsp_id(rid_f),
    .gnt_cnt0(c0_f), .gnt_cnt1(c1_f)
  );

  shift_arbiter #(.RR_EN(1'b1), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(r0rdy_s), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(r1rdy_s), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_mode(req1_mode),
    .rsp_valid(rv_s), .rsp_ready(rsp_ready), .rsp_data(rd_s), .rsp_id(rid_s),
    .gnt_cnt0(c0_s), .gnt_cnt1(c1_s)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drive0(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m);
    req0_valid = 1'b1; req0_data = d; req0_amt = a; req0_mode = m;
  endtask

  task automatic drive1(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m);
    req1_valid = 1'b1; req1_data = d; req1_amt = a; req1_mode = m;
  endtask

  // Single port-0 request with full throughput; result checked after the edge.
  task automatic mode_case(input string tag, input logic [15:0] d, input logic [3:0] a,
                           input logic [1:0] m, input logic [15:0] exp);
    drive0(d, a, m);
    #1 check({tag, "_rdy"}, 16'(r0rdy_a), 16'd1);
    tick();
    check(tag, rd_a, exp);
  endtask

  initial begin
    req0_data = '0; req0_amt = '0; req0_mode = '0;
    req1_data = '0; req1_amt = '0; req1_mode = '0;
    do_reset();

    // Reset state
    check("rst_valid", 16'(rv_a), 16'd0);
    check("rst_data",  rd_a, 16'h0000);
    check("rst_id",    16'(rid_a), 16'd0);
    check("rst_cnt0",  16'(c0_a), 16'd0);
    check("rst_cnt1",  16'(c1_a), 16'd0);

    // Single request: SRA 0x8000 by 4
    drive0(16'h8000, 4'd4, 2'd1);
    #1 check("single_rdy0", 16'(r0rdy_a), 16'd1);
    check("single_rdy1", 16'(r1rdy_a), 16'd0);
    tick();
    req0_valid = 1'b0;
    check("single_valid", 16'(rv_a), 16'd1);
    check("single_data",  rd_a, 16'hF800);
    check("single_id",    16'(rid_a), 16'd0);
    check("single_cnt0",  16'(c0_a), 16'd1);
    tick();
    check("drain_valid", 16'(rv_a), 16'd0);
    check("drain_data",  rd_a, 16'hF800);

    // Contention: round-robin alternates, fixed priority keeps port 0
    do_reset();
    drive0(16'h00FF, 4'd8, 2'd0);
    drive1(16'h0001, 4'd1, 2'd2);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_rdy0", 16'(r0rdy_a), (i % 2 == 0) ? 16'd1 : 16'd0);
      check("rr_rdy1", 16'(r1rdy_a), (i % 2 == 1) ? 16'd1 : 16'd0);
      check("fp_rdy0", 16'(r0rdy_f), 16'd1);
      check("fp_rdy1", 16'(r1rdy_f), 16'd0);
      tick();
      check("rr_data", rd_a, (i % 2 == 0) ? 16'hFF00 : 16'h8000);
      check("rr_id",   16'(rid_a), (i % 2 == 0) ? 16'd0 : 16'd1);
    end
    check("rr_cnt0", 16'(c0_a), 16'd2);
    check("rr_cnt1", 16'(c1_a), 16'd2);
    check("fp_cnt0", 16'(c0_f), 16'd4);
    check("fp_cnt1", 16'(c1_f), 16'd0);
    check("fp_id",   16'(rid_f), 16'd0);

    // Back-pressure: response held, no grant
    req0_valid = 1'b0;
    drive1(16'h00F0, 4'd4, 2'd0);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_rdy1", 16'(r1rdy_a), 16'd0);
      tick();
      check("bp_valid", 16'(rv_a), 16'd1);
      check("bp_data",  rd_a, 16'h8000);
      check("bp_id",    16'(rid_a), 16'd1);
    end
    check("bp_cnt1", 16'(c1_a), 16'd2);
    rsp_ready = 1'b1;
    #1 check("bp_release_rdy1", 16'(r1rdy_a), 16'd1);
    tick();
    check("bp_release_valid", 16'(rv_a), 16'd1);
    check("bp_release_data",  rd_a, 16'h0F00);
    check("bp_release_id",    16'(rid_a), 16'd1);
    check("bp_release_cnt1",  16'(c1_a), 16'd3);
    // Port 1 was served last, so port 0 wins the next contention
    drive0(16'h00FF, 4'd8, 2'd0);
    #1 check("post_bp_rdy0", 16'(r0rdy_a), 16'd1);
    tick();
    check("post_bp_id", 16'(rid_a), 16'd0);
    req1_valid = 1'b0;

    // Edge modes
    mode_case("ror_amt0",  16'h1234, 4'd0,  2'd2, 16'h1234);
    mode_case("pass",      16'hBEEF, 4'd7,  2'd3, 16'hBEEF);
    mode_case("sll_15",    16'hFFFF, 4'd15, 2'd0, 16'h8000);
    mode_case("sra_15",    16'h7FFF, 4'd15, 2'd1, 16'h0000);
    mode_case("sra_neg15", 16'h8000, 4'd15, 2'd1, 16'hFFFF);
    mode_case("ror_4",     16'h1234, 4'd4,  2'd2, 16'h4123);

    // Saturation with 2-bit counters
    do_reset();
    drive0(16'h0003, 4'd1, 2'd0);
    repeat (5) tick();
    check("sat_cnt0_w2", 16'(c0_s), 16'd3);
    check("sat_cnt0_w8", 16'(c0_a), 16'd5);

    // Asynchronous reset while a response is stalled
    rsp_ready = 1'b0;
    tick();
    check("stall_valid", 16'(rv_a), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 16'(rv_a), 16'd0);
    check("async_rst_data",  rd_a, 16'h0000);
    check("async_rst_cnt",   16'(c0_s), 16'd0);
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
